// File: rtl/milano_pkg.sv
// Shared types for the M-extension issue path: operation codes, issue FSM states
// and the default divider watchdog limit.
package milano_pkg;

    // Bit 2 set marks the division family; bit 1 then separates REM from DIV.
    typedef enum logic [2:0] {
        MD_MUL   = 3'd0,
        MD_MULH  = 3'd1,
        MD_MULSU = 3'd2,
        MD_MULU  = 3'd3,
        MD_DIV   = 3'd4,
        MD_DIVU  = 3'd5,
        MD_REM   = 3'd6,
        MD_REMU  = 3'd7
    } md_opt_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } md_issue_st_e;

    localparam int unsigned MD_DIV_TIMEOUT_DEF = 48;

endpackage

// File: rtl/md_wdog_cnt.sv
// Divider watchdog: cleared by load_i, counts while en_i, flags expiry at LIMIT-1.
module md_wdog_cnt
    import milano_pkg::*;
#(
    parameter int unsigned LIMIT = MD_DIV_TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire_o = en_i && (cnt_q == CW'(LIMIT - 1));

    // Saturate at the limit so a stalled enable can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue controller between EX and the multdiv unit: multiplies pass straight through,
// divides are held and sequenced with a watchdog. Optional macro: MD_DIV_ZERO_FAST_EN.
module md_issue_ctrl
    import milano_pkg::*;
#(
    parameter int unsigned DIV_TIMEOUT = MD_DIV_TIMEOUT_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        md_valid_i,
    input  md_opt_e     md_operate_i,
    input  logic [31:0] md_operand_a_i,
    input  logic [31:0] md_operand_b_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        rd_we_i,
    input  logic        refresh_pip_i,
    output md_opt_e     md_operate_o,
    output logic [31:0] md_operand_a_o,
    output logic [31:0] md_operand_b_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_we_o,
    output logic        div_start_o,
    input  logic        div_done_i,
    input  logic        div_busy_i,
    input  logic        md_rd_we_i,
    input  logic [4:0]  md_rd_waddr_i,
    input  logic [31:0] md_rd_wdata_i,
    output logic        md_stall_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_waddr_o,
    output logic [31:0] wb_wdata_o,
    output logic        md_timeout_o
);

    md_issue_st_e state_q, state_d;
    md_opt_e      op_q;
    logic [31:0]  opA_q, opB_q;
    logic [4:0]   rdAddr_q;
    logic         rdWe_q;

    logic live, idleValid, isDiv, divZero;
    logic acceptMul, acceptDiv, startFire, timeoutHit, fwd;
    logic wdogEn, wdogExpire;

    // Reset and flush both silence every control output in the same cycle.
    assign live      = rst_ni && !refresh_pip_i;
    assign idleValid = live && md_valid_i && (state_q == IDLE);
    assign isDiv     = md_operate_i[2];
`ifdef MD_DIV_ZERO_FAST_EN
    logic fastZero;
    assign divZero   = (md_operand_b_i == 32'd0);
    assign fastZero  = idleValid && isDiv && divZero;
`else
    assign divZero   = 1'b0;
`endif
    assign acceptMul  = idleValid && !isDiv;
    assign acceptDiv  = idleValid && isDiv && !divZero;
    assign startFire  = live && (state_q == START) && !div_busy_i;
    assign wdogEn     = (state_q == WAIT);
    assign timeoutHit = live && wdogEn && wdogExpire && !div_done_i;
    assign fwd        = acceptMul || (live && (state_q == DONE));

    md_wdog_cnt #(
        .LIMIT(DIV_TIMEOUT)
    ) u_wdog (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (startFire),
        .en_i    (wdogEn),
        .expire_o(wdogExpire)
    );

    // A completion arriving on the expiry cycle takes priority over the abort.
    always_comb begin
        state_d = state_q;
        if (refresh_pip_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (acceptDiv) state_d = START;
                START:   if (!div_busy_i) state_d = WAIT;
                WAIT: begin
                    if (div_done_i) begin
                        state_d = DONE;
                    end else if (wdogExpire) begin
                        state_d = IDLE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            op_q     <= MD_MUL;
            opA_q    <= '0;
            opB_q    <= '0;
            rdAddr_q <= '0;
            rdWe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (acceptDiv) begin
                op_q     <= md_operate_i;
                opA_q    <= md_operand_a_i;
                opB_q    <= md_operand_b_i;
                rdAddr_q <= rd_addr_i;
                rdWe_q   <= rd_we_i;
            end
        end
    end

    // Only an idle controller lets EX drive multdiv directly.
    always_comb begin
        md_operate_o   = op_q;
        md_operand_a_o = opA_q;
        md_operand_b_o = opB_q;
        rd_addr_o      = rdAddr_q;
        rd_we_o        = rdWe_q;
        if (rst_ni && (state_q == IDLE)) begin
            md_operate_o   = md_operate_i;
            md_operand_a_o = md_operand_a_i;
            md_operand_b_o = md_operand_b_i;
            rd_addr_o      = rd_addr_i;
            rd_we_o        = rd_we_i;
        end
    end

    always_comb begin
        div_start_o  = startFire;
        md_stall_o   = acceptDiv || (live && ((state_q == START) || (state_q == WAIT)));
        md_timeout_o = timeoutHit;
        wb_we_o      = 1'b0;
        wb_waddr_o   = '0;
        wb_wdata_o   = '0;
        if (fwd) begin
            wb_we_o    = md_rd_we_i;
            wb_waddr_o = md_rd_waddr_i;
            wb_wdata_o = md_rd_wdata_i;
        end
`ifdef MD_DIV_ZERO_FAST_EN
        if (fastZero) begin
            wb_we_o    = rd_we_i;
            wb_waddr_o = rd_addr_i;
            wb_wdata_o = md_operate_i[1] ? md_operand_a_i : 32'hFFFF_FFFF;
        end
`endif
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl; the bench plays the multdiv unit by hand.
// Honours MD_DIV_ZERO_FAST_EN when checking the divide-by-zero path.
module tb_md_issue_ctrl;
    import milano_pkg::*;

    logic        clk_i, rst_ni;
    logic        md_valid_i;
    md_opt_e     md_operate_i;
    logic [31:0] md_operand_a_i, md_operand_b_i;
    logic [4:0]  rd_addr_i;
    logic        rd_we_i, refresh_pip_i;
    md_opt_e     md_operate_o;
    logic [31:0] md_operand_a_o, md_operand_b_o;
    logic [4:0]  rd_addr_o;
    logic        rd_we_o, div_start_o, div_done_i, div_busy_i;
    logic        md_rd_we_i;
    logic [4:0]  md_rd_waddr_i;
    logic [31:0] md_rd_wdata_i;
    logic        md_stall_o, wb_we_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;
    logic        md_timeout_o;

    int total = 0;
    int bad   = 0;

    md_issue_ctrl u_dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .md_valid_i    (md_valid_i),
        .md_operate_i  (md_operate_i),
        .md_operand_a_i(md_operand_a_i),
        .md_operand_b_i(md_operand_b_i),
        .rd_addr_i     (rd_addr_i),
        .rd_we_i       (rd_we_i),
        .refresh_pip_i (refresh_pip_i),
        .md_operate_o  (md_operate_o),
        .md_operand_a_o(md_operand_a_o),
        .md_operand_b_o(md_operand_b_o),
        .rd_addr_o     (rd_addr_o),
        .rd_we_o       (rd_we_o),
        .div_start_o   (div_start_o),
        .div_done_i    (div_done_i),
        .div_busy_i    (div_busy_i),
        .md_rd_we_i    (md_rd_we_i),
        .md_rd_waddr_i (md_rd_waddr_i),
        .md_rd_wdata_i (md_rd_wdata_i),
        .md_stall_o    (md_stall_o),
        .wb_we_o       (wb_we_o),
        .wb_waddr_o    (wb_waddr_o),
        .wb_wdata_o    (wb_wdata_o),
        .md_timeout_o  (md_timeout_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("[TB] FAIL simTimeLimit: got expired expected finished");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic applyStimulus(input logic v, input md_opt_e op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd, input logic we);
        md_valid_i     = v;
        md_operate_i   = op;
        md_operand_a_i = a;
        md_operand_b_i = b;
        rd_addr_i      = rd;
        rd_we_i        = we;
    endtask

    task automatic setMd(input logic we, input logic [4:0] addr, input logic [31:0] data);
        md_rd_we_i    = we;
        md_rd_waddr_i = addr;
        md_rd_wdata_i = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni        = 1'b0;
        refresh_pip_i = 1'b0;
        div_done_i    = 1'b0;
        div_busy_i    = 1'b0;
        applyStimulus(1'b1, MD_DIVU, 32'd100, 32'd7, 5'd3, 1'b1);
        setMd(1'b1, 5'd3, 32'd14);
        settle();
        checkOutput("rstStall", 32'(md_stall_o), 32'd0);
        checkOutput("rstStart", 32'(div_start_o), 32'd0);
        checkOutput("rstWbWe", 32'(wb_we_o), 32'd0);
        checkOutput("rstWbData", wb_wdata_o, 32'd0);
        checkOutput("rstTimeout", 32'(md_timeout_o), 32'd0);
        checkOutput("rstOpA", md_operand_a_o, 32'd0);
        applyStimulus(1'b0, MD_MUL, 32'd0, 32'd0, 5'd0, 1'b0);
        setMd(1'b0, 5'd0, 32'd0);
        tick();
        rst_ni = 1'b1;

        // MULU passes through with zero latency
        tick();
        applyStimulus(1'b1, MD_MULU, 32'hFFFF_FFFF, 32'd2, 5'd5, 1'b1);
        setMd(1'b1, 5'd5, 32'd1);
        settle();
        checkOutput("mulWbWe", 32'(wb_we_o), 32'd1);
        checkOutput("mulWbAddr", 32'(wb_waddr_o), 32'd5);
        checkOutput("mulWbData", wb_wdata_o, 32'd1);
        checkOutput("mulStall", 32'(md_stall_o), 32'd0);
        checkOutput("mulOpA", md_operand_a_o, 32'hFFFF_FFFF);
        checkOutput("mulOpB", md_operand_b_o, 32'd2);
        checkOutput("mulOp", 32'(md_operate_o), 32'(MD_MULU));
        tick();
        applyStimulus(1'b0, MD_MUL, 32'd0, 32'd0, 5'd0, 1'b0);
        setMd(1'b0, 5'd6, 32'hDEAD);
        settle();
        checkOutput("idleWbWe", 32'(wb_we_o), 32'd0);
        checkOutput("idleWbAddr", 32'(wb_waddr_o), 32'd0);
        checkOutput("idleWbData", wb_wdata_o, 32'd0);
        checkOutput("idleStall", 32'(md_stall_o), 32'd0);

        // flush in IDLE rejects a divide
        tick();
        setMd(1'b0, 5'd0, 32'd0);
        applyStimulus(1'b1, MD_DIV, 32'd40, 32'd5, 5'd2, 1'b1);
        refresh_pip_i = 1'b1;
        settle();
        checkOutput("idleFlushStall", 32'(md_stall_o), 32'd0);
        tick();
        refresh_pip_i = 1'b0;
        applyStimulus(1'b0, MD_MUL, 32'd0, 32'd0, 5'd0, 1'b0);
        settle();
        checkOutput("idleFlushStart", 32'(div_start_o), 32'd0);
        checkOutput("idleFlushStall2", 32'(md_stall_o), 32'd0);

        // DIVU 100/7, completion 33 cycles after start
        tick();
        applyStimulus(1'b1, MD_DIVU, 32'd100, 32'd7, 5'd3, 1'b1);
        settle();
        checkOutput("divAccStall", 32'(md_stall_o), 32'd1);
        checkOutput("divAccStart", 32'(div_start_o), 32'd0);
        tick();
        applyStimulus(1'b1, MD_MUL, 32'd55, 32'd1, 5'd9, 1'b0);
        settle();
        checkOutput("startPulse", 32'(div_start_o), 32'd1);
        checkOutput("startStall", 32'(md_stall_o), 32'd1);
        checkOutput("startOpA", md_operand_a_o, 32'd100);
        checkOutput("startOpB", md_operand_b_o, 32'd7);
        checkOutput("startOp", 32'(md_operate_o), 32'(MD_DIVU));
        checkOutput("startRd", 32'(rd_addr_o), 32'd3);
        for (int i = 1; i <= 33; i++) begin
            tick();
            div_done_i = (i == 33);
            settle();
            checkOutput("waitStart", 32'(div_start_o), 32'd0);
            checkOutput("waitStall", 32'(md_stall_o), 32'd1);
            checkOutput("waitOpA", md_operand_a_o, 32'd100);
            checkOutput("waitOpB", md_operand_b_o, 32'd7);
            checkOutput("waitWbWe", 32'(wb_we_o), 32'd0);
        end
        tick();
        div_done_i = 1'b0;
        setMd(1'b1, 5'd3, 32'd14);
        applyStimulus(1'b1, MD_DIVU, 32'd8, 32'd2, 5'd6, 1'b1);
        settle();
        checkOutput("doneWbWe", 32'(wb_we_o), 32'd1);
        checkOutput("doneWbAddr", 32'(wb_waddr_o), 32'd3);
        checkOutput("doneWbData", wb_wdata_o, 32'd14);
        checkOutput("doneStall", 32'(md_stall_o), 32'd0);
        checkOutput("doneOpA", md_operand_a_o, 32'd100);
        tick();
        applyStimulus(1'b0, MD_MUL, 32'd0, 32'd0, 5'd0, 1'b0);
        setMd(1'b0, 5'd0, 32'd0);
        settle();
        checkOutput("postDoneStart", 32'(div_start_o), 32'd0);
        checkOutput("postDoneStall", 32'(md_stall_o), 32'd0);

        // flush on the 10th WAIT cycle
        tick();
        applyStimulus(1'b1, MD_DIV, 32'hFFFF_FFEC, 32'd3, 5'd7, 1'b1);
        settle();
        checkOutput("flAccStall", 32'(md_stall_o), 32'd1);
        tick();
        applyStimulus(1'b0, MD_MUL, 32'd0, 32'd0, 5'd0, 1'b0);
        settle();
        checkOutput("flStart", 32'(div_start_o), 32'd1);
        for (int i = 1; i <= 9; i++) begin
            tick();
        end
        tick();
        refresh_pip_i = 1'b1;
        settle();
        checkOutput("flushStall", 32'(md_stall_o), 32'd0);
        checkOutput("flushWbWe", 32'(wb_we_o), 32'd0);
        checkOutput("flushStart", 32'(div_start_o), 32'd0);
        tick();
        refresh_pip_i = 1'b0;
        div_done_i    = 1'b1;
        settle();
        checkOutput("flushIdleStall", 32'(md_stall_o), 32'd0);
        tick();
        div_done_i = 1'b0;
        setMd(1'b1, 5'd7, 32'hFFFF_FFFA);
        settle();
        checkOutput("flushNoWb", 32'(wb_we_o), 32'd0);
        tick();
        setMd(1'b0, 5'd0, 32'd0);

        // watchdog abort at 48 cycles after start
        applyStimulus(1'b1, MD_REM, 32'd5, 32'd2, 5'd8, 1'b1);
        tick();
        applyStimulus(1'b0, MD_MUL, 32'd0, 32'd0, 5'd0, 1'b0);
        settle();
        checkOutput("toStart", 32'(div_start_o), 32'd1);
        for (int i = 1; i <= 47; i++) begin
            tick();
            settle();
            checkOutput("toEarly", 32'(md_timeout_o), 32'd0);
        end
        tick();
        setMd(1'b1, 5'd8, 32'd1);
        settle();
        checkOutput("toPulse", 32'(md_timeout_o), 32'd1);
        checkOutput("toWbWe", 32'(wb_we_o), 32'd0);
        tick();
        settle();
        checkOutput("toAfter", 32'(md_timeout_o), 32'd0);
        checkOutput("toIdleStall", 32'(md_stall_o), 32'd0);
        checkOutput("toIdleWbWe", 32'(wb_we_o), 32'd0);
        setMd(1'b0, 5'd0, 32'd0);

        // completion coinciding with expiry wins
        tick();
        applyStimulus(1'b1, MD_REMU, 32'd77, 32'd100, 5'd9, 1'b1);
        tick();
        applyStimulus(1'b0, MD_MUL, 32'd0, 32'd0, 5'd0, 1'b0);
        for (int i = 1; i <= 47; i++) begin
            tick();
        end
        tick();
        div_done_i = 1'b1;
        settle();
        checkOutput("coTimeout", 32'(md_timeout_o), 32'd0);
        tick();
        div_done_i = 1'b0;
        setMd(1'b1, 5'd9, 32'd77);
        settle();
        checkOutput("coWbWe", 32'(wb_we_o), 32'd1);
        checkOutput("coWbData", wb_wdata_o, 32'd77);
        tick();
        setMd(1'b0, 5'd0, 32'd0);

        // start held off while the divider is busy
        applyStimulus(1'b1, MD_DIVU, 32'd50, 32'd5, 5'd1, 1'b1);
        div_busy_i = 1'b1;
        tick();
        applyStimulus(1'b0, MD_MUL, 32'd0, 32'd0, 5'd0, 1'b0);
        settle();
        checkOutput("busyStart", 32'(div_start_o), 32'd0);
        checkOutput("busyStall", 32'(md_stall_o), 32'd1);
        tick();
        settle();
        checkOutput("busyStart2", 32'(div_start_o), 32'd0);
        tick();
        div_busy_i = 1'b0;
        settle();
        checkOutput("busyRelease", 32'(div_start_o), 32'd1);
        tick();
        refresh_pip_i = 1'b1;
        settle();
        checkOutput("busyNoRestart", 32'(div_start_o), 32'd0);
        tick();
        refresh_pip_i = 1'b0;

        // divide by zero
        applyStimulus(1'b1, MD_REMU, 32'd9, 32'd0, 5'd4, 1'b1);
        settle();
`ifdef MD_DIV_ZERO_FAST_EN
        checkOutput("dzWbWe", 32'(wb_we_o), 32'd1);
        checkOutput("dzWbAddr", 32'(wb_waddr_o), 32'd4);
        checkOutput("dzWbData", wb_wdata_o, 32'd9);
        checkOutput("dzStall", 32'(md_stall_o), 32'd0);
        checkOutput("dzStart", 32'(div_start_o), 32'd0);
        tick();
        applyStimulus(1'b1, MD_DIVU, 32'd9, 32'd0, 5'd4, 1'b1);
        settle();
        checkOutput("dzDivData", wb_wdata_o, 32'hFFFF_FFFF);
        checkOutput("dzDivStall", 32'(md_stall_o), 32'd0);
        tick();
        applyStimulus(1'b0, MD_MUL, 32'd0, 32'd0, 5'd0, 1'b0);
        settle();
        checkOutput("dzAfterStart", 32'(div_start_o), 32'd0);
        checkOutput("dzAfterStall", 32'(md_stall_o), 32'd0);
`else
        checkOutput("dzStall", 32'(md_stall_o), 32'd1);
        checkOutput("dzWbWe", 32'(wb_we_o), 32'd0);
        tick();
        applyStimulus(1'b0, MD_MUL, 32'd0, 32'd0, 5'd0, 1'b0);
        settle();
        checkOutput("dzStart", 32'(div_start_o), 32'd1);
        checkOutput("dzOpB", md_operand_b_o, 32'd0);
        tick();
        div_done_i = 1'b1;
        settle();
        checkOutput("dzWaitStall", 32'(md_stall_o), 32'd1);
        tick();
        div_done_i = 1'b0;
        setMd(1'b1, 5'd4, 32'd9);
        settle();
        checkOutput("dzDoneWbWe", 32'(wb_we_o), 32'd1);
        checkOutput("dzDoneWbData", wb_wdata_o, 32'd9);
        tick();
        setMd(1'b0, 5'd0, 32'd0);
`endif

        // reset in the middle of WAIT
        tick();
        applyStimulus(1'b1, MD_DIV, 32'd64, 32'd4, 5'd10, 1'b1);
        tick();
        applyStimulus(1'b0, MD_DIV, 32'd64, 32'd4, 5'd10, 1'b1);
        tick();
        tick();
        settle();
        checkOutput("preRstStall", 32'(md_stall_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        checkOutput("midRstStall", 32'(md_stall_o), 32'd0);
        checkOutput("midRstStart", 32'(div_start_o), 32'd0);
        checkOutput("midRstWbWe", 32'(wb_we_o), 32'd0);
        checkOutput("midRstTimeout", 32'(md_timeout_o), 32'd0);
        checkOutput("midRstOpA", md_operand_a_o, 32'd0);
        tick();
        tick();
        rst_ni     = 1'b1;
        div_done_i = 1'b1;
        settle();
        checkOutput("relStall", 32'(md_stall_o), 32'd0);
        tick();
        div_done_i = 1'b0;
        setMd(1'b1, 5'd10, 32'd16);
        settle();
        checkOutput("relNoWb", 32'(wb_we_o), 32'd0);
        tick();
        setMd(1'b0, 5'd0, 32'd0);
        applyStimulus(1'b0, MD_MUL, 32'd0, 32'd0, 5'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
